gpc7_3_pipe: RTL and testbench
==============================

Name: gpc7_3_pipe

Overview:
- Registered 7:3 generalized parallel counter (GPC): counts the ones in a 7-bit column and outputs the 3-bit binary sum.
- Building block for compressor trees in multi-operand adders and multipliers.
- Supports LANES independent columns processed in parallel, with a valid bit carried alongside the data.
- Combinational core is the classic 4-full-adder 7:3 compressor.

Parameters:
- LANES, 1, number of independent 7:3 counters instantiated side by side (legal range 1..64).
- PIPE, 0, extra internal register stage between first and second adder levels: 0 gives latency 1, 1 gives latency 2.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  src0 holds valid data this cycle.
- src0  input  7*LANES  lane k occupies bits [7k+6:7k]; every bit has weight 1.
- out_valid  output  1  dst holds a valid result.
- dst  output  3*LANES  lane k occupies bits [3k+2:3k]; unsigned count of ones in src0 lane k.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-low (clk, rst_n).
- Function per lane: dst_k = popcount(src0_k), range 0..7. It is exact with no overflow, since 7 ones fit in 3 bits.
- Latency:
  - PIPE=0: dst/out_valid update on the first rising edge after the input is sampled (1 cycle).
  - PIPE=1: 2 cycles.
  - out_valid is in_valid delayed by the same latency.
- Throughput: one new input vector per cycle, no stall or backpressure.
- Reset: while rst_n=0 at a clock edge, all pipeline registers clear, so dst=0 and out_valid=0.
- Reset mid-operation: in-flight data is discarded and no valid output emerges for inputs sampled before the reset edge.
- After rst_n deasserts, the first valid result appears exactly one latency period after the first sampled in_valid=1.
- Gating: dst registers load only when the corresponding stage valid is 1 and otherwise hold their previous value. Bench checks dst only when out_valid=1.
- Combinational core structure (per lane):
  - FA1(s0,s1,s2) -> (a0,c0); FA2(s3,s4,s5) -> (a1,c1); FA3(a0,a1,s6) -> (dst[0],c2); FA4(c0,c1,c2) -> (dst[1],dst[2]).
  - PIPE=1 registers a0, a1, c0, c1 and s6 between FA1/FA2 and FA3/FA4.
- Lanes are fully independent; there is no carry between lanes.
- X on src0 while in_valid=0 must not propagate to dst.

Decomposition:
- Package gpc_pkg holds:
  - localparam GPC_IN_W=7 and GPC_OUT_W=3;
  - a function popcount7 for use by the bench model.
- Sub-module gpc7_3_core: purely combinational single-lane compressor built from four full_adder instances.
  - full_adder is a tiny leaf: sum = a^b^c, carry = majority.
- Top level gpc7_3_pipe generates LANES cores plus the valid/data pipeline registers for PIPE=0/1.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with random src0 -> dst=0 and out_valid=0 throughout. Release -> outputs stay 0 until the first valid input.
- Directed vectors, LANES=1, PIPE=0, in_valid=1 each cycle: 7'h50->2, 7'h39->4, 7'h09->2, 7'h04->1, 7'h4c->3, 7'h1f->5, 7'h2f->5, 7'h5d->5, 7'h00->0, 7'h7f->7. Each result appears one cycle later with out_valid=1.
- Exhaustive sweep of all 128 inputs at PIPE=0 and PIPE=1 against popcount7 -> zero mismatches. Back-to-back stream gives out_valid continuously high after the latency.
- Valid gating: alternate in_valid 1/0 with X or garbage on src0 when invalid -> out_valid follows the pattern delayed by the latency, and dst holds its last valid value during gaps.
- Multi-lane: LANES=4, src0 lanes = {7'h7f, 7'h00, 7'h6a, 7'h10} (lane 3..0) -> dst = {3'd7, 3'd0, 3'd4, 3'd1}, with no cross-lane interference.
- Reset mid-stream: PIPE=1, assert rst_n=0 for one cycle while two results are in flight -> neither result emerges, and out_valid=0 on the following cycles until new input arrives.

Source files
------------

// File: rtl/gpc_pkg.sv
// gpc_pkg: shared widths and a reference popcount for 7:3 counters
package gpc_pkg;
  localparam int GPC_IN_W = 7;
  localparam int GPC_OUT_W = 3;
  localparam int GPC_MID_W = 5;
  function automatic logic [GPC_OUT_W-1:0] popcount7(input logic [GPC_IN_W-1:0] v);
    logic [GPC_OUT_W-1:0] n;
    n = '0;
    for (int i = 0; i < GPC_IN_W; i++) n = n + {2'b0, v[i]};
    return n;
  endfunction
endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit full adder leaf
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);
  assign sum = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/gpc7_3_core.sv
// gpc7_3_core: single-lane 7:3 compressor, split into two adder levels
module gpc7_3_core
  import gpc_pkg::*;
(
  input  logic [GPC_IN_W-1:0]  s,
  output logic [GPC_MID_W-1:0] mid,
  input  logic [GPC_MID_W-1:0] mid_q,
  output logic [GPC_OUT_W-1:0] sum
);
  // mid = {s6, c1, c0, a1, a0}; mid_q is mid either direct or registered
  logic c2;
  full_adder fa1 (.a(s[0]), .b(s[1]), .c(s[2]), .sum(mid[0]), .carry(mid[2]));
  full_adder fa2 (.a(s[3]), .b(s[4]), .c(s[5]), .sum(mid[1]), .carry(mid[3]));
  assign mid[4] = s[6];
  full_adder fa3 (.a(mid_q[0]), .b(mid_q[1]), .c(mid_q[4]), .sum(sum[0]), .carry(c2));
  full_adder fa4 (.a(mid_q[2]), .b(mid_q[3]), .c(c2), .sum(sum[1]), .carry(sum[2]));
endmodule

// File: rtl/gpc7_3_pipe.sv
// gpc7_3_pipe: registered multi-lane 7:3 counter with optional mid-level stage
module gpc7_3_pipe
  import gpc_pkg::*;
#(
  parameter int LANES = 1,
  parameter int PIPE = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [GPC_IN_W*LANES-1:0]  src0,
  output logic                       out_valid,
  output logic [GPC_OUT_W*LANES-1:0] dst
);
  logic [GPC_MID_W*LANES-1:0] mid, mid_q;
  logic [GPC_OUT_W*LANES-1:0] sum;
  logic v_s;
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    gpc7_3_core u_core (
      .s(src0[GPC_IN_W*k +: GPC_IN_W]),
      .mid(mid[GPC_MID_W*k +: GPC_MID_W]),
      .mid_q(mid_q[GPC_MID_W*k +: GPC_MID_W]),
      .sum(sum[GPC_OUT_W*k +: GPC_OUT_W])
    );
  end
  if (PIPE != 0) begin : g_pipe
    logic v1;
    logic [GPC_MID_W*LANES-1:0] mid_r;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v1 <= 1'b0;
        mid_r <= '0;
      end else begin
        v1 <= in_valid;
        if (in_valid) mid_r <= mid;
      end
    end
    assign mid_q = mid_r;
    assign v_s = v1;
  end else begin : g_nopipe
    assign mid_q = mid;
    assign v_s = in_valid;
  end
  // data only loads on a valid stage, so garbage on idle cycles never lands
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      dst <= '0;
    end else begin
      out_valid <= v_s;
      if (v_s) dst <= sum;
    end
  end
endmodule

// File: tb/tb_gpc7_3_pipe.sv
// tb_gpc7_3_pipe: directed and exhaustive checks for gpc7_3_pipe
module tb_gpc7_3_pipe;
  import gpc_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [6:0] src = '0;
  logic [27:0] src4 = '0;
  logic ov0, ov1, ov4;
  logic [2:0] d0, d1;
  logic [11:0] d4;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  gpc7_3_pipe #(.LANES(1), .PIPE(0)) u0 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .src0(src), .out_valid(ov0), .dst(d0));
  gpc7_3_pipe #(.LANES(1), .PIPE(1)) u1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .src0(src), .out_valid(ov1), .dst(d1));
  gpc7_3_pipe #(.LANES(4), .PIPE(1)) u4 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .src0(src4), .out_valid(ov4), .dst(d4));
  typedef struct { logic [6:0] s; logic [2:0] e; } vec_t;
  vec_t vecs [10];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  initial begin
    logic [2:0] prev_e, last0, last1;
    logic prev_v;
    vecs[0] = '{7'h50, 3'd2}; vecs[1] = '{7'h39, 3'd4}; vecs[2] = '{7'h09, 3'd2};
    vecs[3] = '{7'h04, 3'd1}; vecs[4] = '{7'h4c, 3'd3}; vecs[5] = '{7'h1f, 3'd5};
    vecs[6] = '{7'h2f, 3'd5}; vecs[7] = '{7'h5d, 3'd5}; vecs[8] = '{7'h00, 3'd0};
    vecs[9] = '{7'h7f, 3'd7};
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      src = 7'($urandom);
      src4 = 28'($urandom);
      tick();
      chk("rst_ov", {29'b0, ov0, ov1, ov4}, 32'd0);
      chk("rst_dst", {14'b0, d0, d1, d4}, 32'd0);
    end
    rst_n = 1'b1;
    in_valid = 1'b0;
    src4 = '0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("idle_ov", {29'b0, ov0, ov1, ov4}, 32'd0);
      chk("idle_dst", {14'b0, d0, d1, d4}, 32'd0);
    end
    in_valid = 1'b1;
    prev_e = '0;
    for (int i = 0; i < 10; i++) begin
      src = vecs[i].s;
      tick();
      chk("vec_ov0", {31'b0, ov0}, 32'd1);
      chk("vec_d0", {29'b0, d0}, {29'b0, vecs[i].e});
      chk("vec_ov1", {31'b0, ov1}, (i > 0) ? 32'd1 : 32'd0);
      if (i > 0) chk("vec_d1", {29'b0, d1}, {29'b0, prev_e});
      prev_e = vecs[i].e;
    end
    for (int i = 0; i < 128; i++) begin
      src = 7'(i);
      tick();
      chk("swp_ov0", {31'b0, ov0}, 32'd1);
      chk("swp_d0", {29'b0, d0}, {29'b0, popcount7(7'(i))});
      chk("swp_ov1", {31'b0, ov1}, 32'd1);
      chk("swp_d1", {29'b0, d1}, {29'b0, (i > 0) ? popcount7(7'(i - 1)) : 3'd7});
    end
    in_valid = 1'b0;
    src = 7'($urandom);
    tick();
    chk("tail_ov0", {31'b0, ov0}, 32'd0);
    chk("tail_ov1", {31'b0, ov1}, 32'd1);
    chk("tail_d1", {29'b0, d1}, 32'd7);
    last0 = 3'd7;
    last1 = 3'd7;
    prev_v = 1'b0;
    for (int i = 0; i < 12; i++) begin
      logic v;
      v = (i % 2 == 0);
      in_valid = v;
      src = v ? 7'(i * 13 + 5) : 7'($urandom);
      tick();
      if (v) last0 = popcount7(7'(i * 13 + 5));
      chk("gate_ov0", {31'b0, ov0}, {31'b0, v});
      chk("gate_d0", {29'b0, d0}, {29'b0, last0});
      chk("gate_ov1", {31'b0, ov1}, {31'b0, prev_v});
      chk("gate_d1", {29'b0, d1}, {29'b0, last1});
      last1 = last0;
      prev_v = v;
    end
    in_valid = 1'b1;
    src4 = {7'h7f, 7'h00, 7'h6a, 7'h10};
    tick();
    src4 = {7'h10, 7'h6a, 7'h00, 7'h7f};
    tick();
    chk("lane_ov", {31'b0, ov4}, 32'd1);
    chk("lane_a", {20'b0, d4}, {20'b0, 3'd7, 3'd0, 3'd4, 3'd1});
    in_valid = 1'b0;
    src4 = 28'($urandom);
    tick();
    chk("lane_b", {20'b0, d4}, {20'b0, 3'd1, 3'd4, 3'd0, 3'd7});
    tick();
    chk("lane_hold_ov", {31'b0, ov4}, 32'd0);
    chk("lane_hold", {20'b0, d4}, {20'b0, 3'd1, 3'd4, 3'd0, 3'd7});
    in_valid = 1'b1;
    src = 7'h7f;
    src4 = '1;
    tick();
    src = 7'h03;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mrst_ov", {29'b0, ov0, ov1, ov4}, 32'd0);
      chk("mrst_dst", {14'b0, d0, d1, d4}, 32'd0);
    end
    in_valid = 1'b1;
    src = 7'h15;
    tick();
    in_valid = 1'b0;
    chk("post_ov1_early", {31'b0, ov1}, 32'd0);
    tick();
    chk("post_ov1", {31'b0, ov1}, 32'd1);
    chk("post_d1", {29'b0, d1}, 32'd3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
